ifu_prefetch: RTL
=================

# ifu_prefetch

Parametrised instruction fetch unit with a prefetch buffer, replacing the single-instruction ifu/pc pair in the core front end. It owns the fetch PC, streams sequential word fetches from the synchronous instruction ROM, and buffers up to DEPTH fetched instructions with their PCs. It presents them to id/ex through a valid/ready handshake, and flushes and redirects on an ex-stage jump.

## Interface
- XLEN, 32, data and address width in bits.
- DEPTH, 4, prefetch buffer entries; a power of two, minimum 2.
- RESET_ADDR, 0, byte address of the first fetch after reset.

- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- rom_en  output  1  fetch request issued this cycle.
- rom_addr  output  XLEN  byte address of the request; always 4-aligned.
- rom_data  input  XLEN  ROM read data, valid exactly one cycle after rom_en.
- pc_jump  input  1  redirect request from ex.
- pc_jump_addr  input  XLEN  redirect target; bits [1:0] are forced to 0.
- inst_valid  output  1  inst/inst_pc hold a fetched instruction.
- inst_ready  input  1  consumer accepts the instruction this cycle.
- inst  output  XLEN  instruction word.
- inst_pc  output  XLEN  byte address of inst.

## Operation
- State:
  - fetch_pc (XLEN): next address to request.
  - inflight (1 bit): a response is due this cycle.
  - FIFO of DEPTH entries of {pc, inst}, with rd_ptr/wr_ptr and a count in the range 0..DEPTH.
- Issue rule: rom_en=1 when !rst && !pc_jump && (count + inflight) < DEPTH. On issue, rom_addr=fetch_pc, fetch_pc <= fetch_pc+4 (wraps modulo 2^XLEN), and inflight <= 1. Otherwise inflight <= 0.
- Response: when inflight=1, {pc of request, rom_data} is pushed into the FIFO; the pc is held in a one-entry tag register.
- Pop: an entry is removed when inst_valid && inst_ready.
- Push and pop in the same cycle leave count unchanged. Because of the issue rule, the FIFO never overflows, and a push is never dropped for lack of space.
- Jump (pc_jump=1):
  - FIFO emptied (count <= 0, pointers reset).
  - inflight response due next cycle discarded (inflight <= 0).
  - fetch_pc <= {pc_jump_addr[XLEN-1:2], 2'b00}.
  - No issue in the jump cycle.
  - Any pop in the same cycle is ignored.
  - A response arriving in the jump cycle is also discarded.
- Consecutive jumps: the last one wins; each cycle with pc_jump=1 suppresses issue.
- inst_valid=0 never accepts inst_ready; inst/inst_pc are don't-care when invalid but are driven to 0 at reset.

## Timing
- Reset: fetch_pc=RESET_ADDR, count=0, inflight=0, inst_valid=0, inst=0, inst_pc=0. rom_en=0 during reset and rom_addr=RESET_ADDR.
- First fetch: in the first cycle after rst falls (T0), rom_en=1 and rom_addr=RESET_ADDR. The data returns in T1.
- Fetch-to-valid latency is 1 cycle with bypass and 2 cycles without (see Configuration).
- Sustained throughput is one instruction per cycle with inst_ready held high.
- Jump-to-first-target-instruction:
  - Jump at J; issue at J+1.
  - Valid at J+2 with bypass, J+3 without.
- Reset asserted mid-stream: all state returns to reset values at the next edge. In-flight responses are discarded.

## Configuration
- IFU_PREFETCH_BYPASS_EN defined:
  - When the FIFO is empty and a response arrives, inst_valid=1 in that same cycle, with inst=rom_data and inst_pc=tag.
  - If inst_ready=1, the entry is consumed without being written to the FIFO. Otherwise it is pushed.
- Not defined:
  - Responses are always pushed first, and the outputs come from the FIFO head only.
  - This adds one cycle of latency; throughput is unchanged.

## Test plan
- Reset release, inst_ready=1, ROM holding word i at address 4i:
  - rom_addr sequence 0,4,8,… one per cycle.
  - inst_pc/inst = 0/word0 at T1 (bypass) or T2 (no bypass).
  - Then one instruction per cycle with no gaps.
- inst_ready=0 from reset:
  - Exactly DEPTH (4) issues happen, then rom_en stays 0 and count=4.
  - Raising inst_ready drains 0,4,8,12 in order and resumes fetch at 16.
- pc_jump=1 with pc_jump_addr=0x40 while count=3 and inflight=1:
  - inst_valid drops the next cycle and no stale PC ever appears.
  - The next rom_addr is 0x40 at J+1, and inst_pc=0x40 is the next instruction delivered.
- pc_jump_addr=0x43: the fetch is redirected to 0x40.
- Jumps on two consecutive cycles (0x80 then 0x100): only 0x100 is fetched, and no instruction from 0x80 is delivered.
- Random inst_ready over 1000 cycles with random jumps, checked against a reference model:
  - Delivered inst_pc values are sequential between jumps.
  - count never exceeds DEPTH.
  - rst asserted at cycle 500 restores every output to its reset value at the next edge.

Source files
------------

// File: rtl/ifu_prefetch.sv
// ifu_prefetch: fetch PC plus a DEPTH-entry {pc, inst} prefetch FIFO with jump flush.
// Define IFU_PREFETCH_BYPASS_EN to forward a response straight to the outputs when the FIFO is empty.
module ifu_prefetch #(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_ADDR = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            rom_en,
  output logic [XLEN-1:0] rom_addr,
  input  logic [XLEN-1:0] rom_data,
  input  logic            pc_jump,
  input  logic [XLEN-1:0] pc_jump_addr,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc
);
  localparam int AW = $clog2(DEPTH);
  logic [XLEN-1:0] r_fetch_pc, r_tag;
  logic            r_inflight;
  logic [XLEN-1:0] r_mem_pc [DEPTH];
  logic [XLEN-1:0] r_mem_inst [DEPTH];
  logic [AW-1:0]   r_rd_ptr, r_wr_ptr;
  logic [AW:0]     r_count;
  logic [AW:0]     w_occ;
  logic            w_empty, w_issue, w_byp, w_push, w_pop;
  // Counting the in-flight response reserves its slot, so a push always has room.
  assign w_occ   = r_count + (AW+1)'(r_inflight);
  assign w_empty = r_count == '0;
  assign w_issue = !rst && !pc_jump && (w_occ < (AW+1)'(DEPTH));
`ifdef IFU_PREFETCH_BYPASS_EN
  assign w_byp = r_inflight && w_empty;
`else
  assign w_byp = 1'b0;
`endif
  assign w_pop      = !w_empty && inst_ready && !pc_jump;
  assign w_push     = r_inflight && !pc_jump && !(w_byp && inst_ready);
  assign rom_en     = w_issue;
  assign rom_addr   = rst ? RESET_ADDR : r_fetch_pc;
  assign inst_valid = !w_empty || w_byp;
  assign inst       = !w_empty ? r_mem_inst[r_rd_ptr] : w_byp ? rom_data : '0;
  assign inst_pc    = !w_empty ? r_mem_pc[r_rd_ptr] : w_byp ? r_tag : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_ADDR;
      r_tag      <= '0;
      r_inflight <= 1'b0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_fetch_pc <= r_fetch_pc + XLEN'(4);
        r_tag      <= r_fetch_pc;
      end
      if (pc_jump) begin
        r_fetch_pc <= {pc_jump_addr[XLEN-1:2], 2'b00};
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
        r_count    <= '0;
      end else begin
        if (w_push) begin
          r_mem_pc[r_wr_ptr]   <= r_tag;
          r_mem_inst[r_wr_ptr] <= rom_data;
          r_wr_ptr             <= r_wr_ptr + 1'b1;
        end
        if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
        r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
    end
  end
endmodule
